// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Stall/flush sequencer for a classic 5-stage pipeline. It looks at the
// instruction in ID, the ID/EX latch and the EX/MEM latch, and produces the
// load enables and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//
// Handled events (highest priority first):
//   1. data-memory wait  : EX/MEM holds a load/store and memory is not ready
//   2. taken branch      : EX/MEM holds a branch with zero_flag set
//   3. load-use hazard   : ID reads a register that the load in ID/EX writes
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_rs, id_rt, id_uses_rt   source registers of the instruction in ID
//   ex_rd, ex_mem_read         destination / load flag held in ID/EX
//   mem_branch, mem_zero       branch and zero flag held in EX/MEM
//   mem_read, mem_write        memory request held in EX/MEM
//   mem_ready                  data memory completes its access this cycle
//   pc_write, pc_src           PC load enable, select branch target
//   ifid_write, ifid_flush     IF/ID load enable, clear to NOP
//   idex_write, idex_flush     ID/EX load enable, load bubble
//   exmem_write, exmem_flush   EX/MEM load enable, load zero control
//   memwb_bubble               MEM/WB loads reg_write=0
//   stall_cycles               saturating count of cycles with pc_write=0
//   mem_err                    sticky memory-timeout flag
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int LU_BUBBLES  = 1,   // bubbles per load-use hazard (1..7)
  parameter int MEM_TIMEOUT = 64,  // max frozen cycles per memory wait (2..255)
  parameter int CNT_W       = 16   // width of stall_cycles
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // Last bubble index while in LU_STALL, and the wait-count that triggers a
  // forced release.
  localparam logic [2:0] LU_LAST    = 3'(LU_BUBBLES - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [2:0]       bub_cnt_q, bub_cnt_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             mem_err_q, mem_err_d;

  logic mem_req;
  logic branch_taken;
  logic lu_hazard;

  // Control values before the reset gate.
  logic pc_write_c, pc_src_c, ifid_write_c, ifid_flush_c;
  logic idex_write_c, idex_flush_c, exmem_write_c, exmem_flush_c;
  logic memwb_bubble_c;
  logic freeze_c;   // memory wait holds the whole pipe this cycle
  logic decode_c;   // cycle resolves branch / load-use as in RUN

  assign mem_req      = mem_read | mem_write;
  assign branch_taken = mem_branch & mem_zero;
  // $0 is hard-wired, so a load targeting it never creates a dependency.
  assign lu_hazard    = ex_mem_read && (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    pc_write_c     = 1'b1;
    pc_src_c       = 1'b0;
    ifid_write_c   = 1'b1;
    ifid_flush_c   = 1'b0;
    idex_write_c   = 1'b1;
    idex_flush_c   = 1'b0;
    exmem_write_c  = 1'b1;
    exmem_flush_c  = 1'b0;
    memwb_bubble_c = 1'b0;
    freeze_c       = 1'b0;
    decode_c       = 1'b0;
    state_d        = RUN;
    bub_cnt_d      = 3'd0;
    wait_cnt_d     = 8'd0;
    mem_err_d      = mem_err_q;

    case (state_q)
      MEM_WAIT: begin
        if (mem_ready) begin
          decode_c = 1'b1;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          // Give up on the memory: flag it and let the access retire.
          mem_err_d = 1'b1;
          decode_c  = 1'b1;
        end else begin
          freeze_c   = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        // RUN or LU_STALL; a memory wait abandons any pending bubbles.
        if (mem_req && !mem_ready) begin
          freeze_c   = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          decode_c = 1'b1;
        end
      end
    endcase

    if (freeze_c) begin
      pc_write_c     = 1'b0;
      ifid_write_c   = 1'b0;
      idex_write_c   = 1'b0;
      exmem_write_c  = 1'b0;
      memwb_bubble_c = 1'b1;
    end

    if (decode_c) begin
      if (branch_taken) begin
        // The instruction being stalled (if any) is squashed, so the
        // branch wins over a load-use stall.
        pc_src_c      = 1'b1;
        ifid_flush_c  = 1'b1;
        idex_flush_c  = 1'b1;
        exmem_flush_c = 1'b1;
      end else if (state_q == LU_STALL) begin
        // ID/EX already holds a bubble, so the stall continues regardless
        // of the live hazard inputs.
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        idex_flush_c = 1'b1;
        if (bub_cnt_q != LU_LAST) begin
          state_d   = LU_STALL;
          bub_cnt_d = bub_cnt_q + 3'd1;
        end
      end else if (lu_hazard) begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        idex_flush_c = 1'b1;
        if (LU_BUBBLES > 1) begin
          state_d   = LU_STALL;
          bub_cnt_d = 3'd1;
        end
      end
    end

    stall_cycles_d = stall_cycles_q;
    if (!pc_write_c && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      bub_cnt_q      <= 3'd0;
      wait_cnt_q     <= 8'd0;
      stall_cycles_q <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bub_cnt_q      <= bub_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_err_q      <= mem_err_d;
    end
  end

  // While reset is asserted nothing in the pipe may load or flush.
  assign pc_write     = rst_n & pc_write_c;
  assign pc_src       = rst_n & pc_src_c;
  assign ifid_write   = rst_n & ifid_write_c;
  assign ifid_flush   = rst_n & ifid_flush_c;
  assign idex_write   = rst_n & idex_write_c;
  assign idex_flush   = rst_n & idex_flush_c;
  assign exmem_write  = rst_n & exmem_write_c;
  assign exmem_flush  = rst_n & exmem_flush_c;
  assign memwb_bubble = rst_n & memwb_bubble_c;
  assign stall_cycles = stall_cycles_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed and random stimulus is applied one cycle at a time. For every
// applied cycle a behavioural model computes the expected controls and pushes
// them into a queue; an independent monitor pops one entry per cycle on the
// falling clock edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int LU_BUBBLES  = 3;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 16;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       mem_branch;
    logic       mem_zero;
    logic       mem_read;
    logic       mem_write;
    logic       mem_ready;
  } stim_t;

  typedef struct packed {
    logic             pc_write;
    logic             pc_src;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             exmem_flush;
    logic             memwb_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_err;
  } resp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs, id_rt, ex_rd;
  logic             id_uses_rt, ex_mem_read;
  logic             mem_branch, mem_zero, mem_read, mem_write, mem_ready;
  logic             pc_write, pc_src, ifid_write, ifid_flush;
  logic             idex_write, idex_flush, exmem_write, exmem_flush;
  logic             memwb_bubble, mem_err;
  logic [CNT_W-1:0] stall_cycles;

  int    n_vec  = 0;
  int    n_err  = 0;
  int    n_push = 0;
  resp_t exp_q[$];
  string phase = "reset";

  // Behavioural model state.
  int          m_left;     // load-use bubbles still owed after this cycle
  bit          m_wait;     // a memory access is outstanding
  int          m_frozen;   // frozen cycles so far in this memory wait
  int unsigned m_stalls;
  bit          m_err;

  pipeline_hazard_ctrl #(
    .LU_BUBBLES (LU_BUBBLES),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .mem_branch  (mem_branch),
    .mem_zero    (mem_zero),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_write  (idex_write),
    .idex_flush  (idex_flush),
    .exmem_write (exmem_write),
    .exmem_flush (exmem_flush),
    .memwb_bubble(memwb_bubble),
    .stall_cycles(stall_cycles),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  // Expected response for one cycle, then advance the model past the edge.
  task automatic model_step(input stim_t s, input logic rst, output resp_t r);
    bit req, taken, haz, freeze;
    r = '0;
    if (!rst) begin
      m_left = 0; m_wait = 0; m_frozen = 0; m_stalls = 0; m_err = 0;
      return;
    end
    r.stall_cycles = m_stalls[CNT_W-1:0];
    r.mem_err      = m_err;
    r.pc_write = 1'b1; r.ifid_write = 1'b1; r.idex_write = 1'b1; r.exmem_write = 1'b1;
    req   = s.mem_read || s.mem_write;
    taken = s.mem_branch && s.mem_zero;
    haz   = s.ex_mem_read && (s.ex_rd != 0) &&
            ((s.ex_rd == s.id_rs) || (s.id_uses_rt && (s.ex_rd == s.id_rt)));
    freeze = 0;
    if (m_wait) begin
      if (!s.mem_ready && m_frozen < MEM_TIMEOUT) begin
        freeze = 1;
        m_frozen++;
      end else begin
        if (!s.mem_ready) m_err = 1;
        m_wait = 0;
      end
    end else if (req && !s.mem_ready) begin
      freeze = 1; m_wait = 1; m_frozen = 1; m_left = 0;
    end
    if (freeze) begin
      r.pc_write = 0; r.ifid_write = 0; r.idex_write = 0; r.exmem_write = 0;
      r.memwb_bubble = 1;
    end else if (taken) begin
      r.pc_src = 1; r.ifid_flush = 1; r.idex_flush = 1; r.exmem_flush = 1;
      m_left = 0;
    end else if (m_left > 0) begin
      r.pc_write = 0; r.ifid_write = 0; r.idex_flush = 1;
      m_left--;
    end else if (haz) begin
      r.pc_write = 0; r.ifid_write = 0; r.idex_flush = 1;
      m_left = LU_BUBBLES - 1;
    end
    if (!r.pc_write && m_stalls < CNT_MAX) m_stalls++;
  endtask

  task automatic apply(input stim_t s, input logic rst);
    resp_t e;
    @(posedge clk);
    #1;
    id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.id_uses_rt;
    ex_rd = s.ex_rd; ex_mem_read = s.ex_mem_read;
    mem_branch = s.mem_branch; mem_zero = s.mem_zero;
    mem_read = s.mem_read; mem_write = s.mem_write; mem_ready = s.mem_ready;
    rst_n = rst;
    model_step(s, rst, e);
    exp_q.push_back(e);
    n_push++;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_rs       = 5'($urandom_range(0, 3));
    s.id_rt       = 5'($urandom_range(0, 3));
    s.id_uses_rt  = 1'($urandom_range(0, 1));
    s.ex_rd       = 5'($urandom_range(0, 3));
    s.ex_mem_read = 1'($urandom_range(0, 1));
    s.mem_branch  = ($urandom_range(0, 3) == 0);
    s.mem_zero    = 1'($urandom_range(0, 1));
    s.mem_read    = ($urandom_range(0, 4) == 0);
    s.mem_write   = ($urandom_range(0, 5) == 0);
    s.mem_ready   = ($urandom_range(0, 2) == 0);
    return s;
  endfunction

  // Monitor: one comparison per applied cycle, away from the active edge.
  initial begin
    resp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_flush, memwb_bubble, stall_cycles, mem_err};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s vec%0d: got pw/ps/fw/ff/dw/df/xw/xf/bub=%b%b%b%b%b%b%b%b%b stalls=%0d err=%b, expected %b%b%b%b%b%b%b%b%b stalls=%0d err=%b",
                   phase, n_vec,
                   a.pc_write, a.pc_src, a.ifid_write, a.ifid_flush, a.idex_write,
                   a.idex_flush, a.exmem_write, a.exmem_flush, a.memwb_bubble,
                   a.stall_cycles, a.mem_err,
                   e.pc_write, e.pc_src, e.ifid_write, e.ifid_flush, e.idex_write,
                   e.idex_flush, e.exmem_write, e.exmem_flush, e.memwb_bubble,
                   e.stall_cycles, e.mem_err);
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rd = '0; ex_mem_read = 1'b0;
    mem_branch = 1'b0; mem_zero = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_ready = 1'b0;

    // Reset held with busy inputs: every control must stay low.
    phase = "reset";
    s = rand_stim();
    repeat (3) apply(s, 1'b0);
    apply('0, 1'b1);

    // Load-use on rs.
    phase = "load_use";
    s = '0; s.ex_mem_read = 1; s.ex_rd = 5'd5; s.id_rs = 5'd5;
    apply(s, 1'b1);
    repeat (LU_BUBBLES + 1) apply('0, 1'b1);

    // $0 and unused rt never stall.
    phase = "no_hazard";
    s = '0; s.ex_mem_read = 1; s.ex_rd = 5'd0; s.id_rs = 5'd0;
    apply(s, 1'b1);
    s = '0; s.ex_mem_read = 1; s.ex_rd = 5'd7; s.id_rt = 5'd7; s.id_rs = 5'd1;
    apply(s, 1'b1);

    // Taken branch overrides a simultaneous load-use hazard.
    phase = "branch_lu";
    s = '0; s.ex_mem_read = 1; s.ex_rd = 5'd5; s.id_rs = 5'd5;
    s.mem_branch = 1; s.mem_zero = 1;
    apply(s, 1'b1);
    apply('0, 1'b1);

    // Memory wait of three cycles, then completion.
    phase = "mem_wait";
    s = '0; s.mem_read = 1; s.mem_ready = 0;
    repeat (3) apply(s, 1'b1);
    s.mem_ready = 1;
    apply(s, 1'b1);
    apply('0, 1'b1);

    phase = "random_a";
    repeat (300) apply(rand_stim(), 1'b1);

    // Clear any outstanding wait or bubbles before the timeout case.
    phase = "drain";
    s = '0; s.mem_ready = 1;
    repeat (LU_BUBBLES + 1) apply(s, 1'b1);

    // Memory never answers: forced release and sticky error.
    phase = "timeout";
    s = '0; s.mem_write = 1; s.mem_ready = 0;
    repeat (MEM_TIMEOUT + 2) apply(s, 1'b1);

    phase = "random_b";
    repeat (200) apply(rand_stim(), 1'b1);

    phase = "drain";
    s = '0; s.mem_ready = 1;
    repeat (LU_BUBBLES + 1) apply(s, 1'b1);

    // Reset pulsed during the second load-use bubble.
    phase = "reset_mid_lu";
    s = '0; s.ex_mem_read = 1; s.ex_rd = 5'd3; s.id_rt = 5'd3; s.id_uses_rt = 1;
    s.mem_ready = 1;
    apply(s, 1'b1);
    apply('0, 1'b0);
    apply('0, 1'b0);
    repeat (3) apply('0, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0 || n_vec != n_push) begin
      n_err++;
      $display("FAIL drain: checked %0d of %0d vectors, %0d left unchecked",
               n_vec, n_push, exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It watches the ID stage, the ID/EX latch and the EX/MEM latch (mem_read, branch, zero_flag, rd). It drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, and keeps a saturating stall-cycle counter and a sticky memory-timeout error.

Parameters:
LU_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (1..7)
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before forced release (2..255)
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_rd  in  5  destination reg held in ID/EX
ex_mem_read  in  1  mem_read held in ID/EX
mem_branch  in  1  branch held in EX/MEM
mem_zero  in  1  zero_flag held in EX/MEM
mem_read  in  1  mem_read held in EX/MEM
mem_write  in  1  mem_write held in EX/MEM
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
pc_src  out  1  1 = load branch_addr from EX/MEM
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_write  out  1  ID/EX load enable
idex_flush  out  1  ID/EX load zero control (bubble)
exmem_write  out  1  EX/MEM load enable
exmem_flush  out  1  EX/MEM load zero control
memwb_bubble  out  1  MEM/WB loads reg_write=0
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0
mem_err  out  1  sticky: memory timeout occurred

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT. The state, a 3-bit bubble counter and an 8-bit wait counter are registered. Control outputs are combinational from state and inputs.
- Reset (rst_n=0, asynchronous): state=RUN, counters=0, stall_cycles=0, mem_err=0. All write enables, flushes, pc_src and memwb_bubble are forced 0 while rst_n=0.
- Default in RUN with no event: all *_write=1, all flushes=0, pc_src=0, memwb_bubble=0.
- Event priority per cycle: mem wait > taken branch > load-use.
- Mem wait: mem_req = mem_read|mem_write.
  - In RUN or LU_STALL, if mem_req and !mem_ready: pc_write, ifid_write, idex_write and exmem_write are 0, memwb_bubble=1, and the state becomes MEM_WAIT with wait_cnt=1.
  - In MEM_WAIT, freeze outputs hold while !mem_ready, and wait_cnt increments.
  - On mem_ready=1: the cycle behaves as RUN (outputs not frozen), next state RUN.
  - If wait_cnt reaches MEM_TIMEOUT with mem_ready still 0: mem_err is set (sticky until reset), that cycle is treated as completed, next state RUN.
  - A pending LU_STALL is abandoned; the hazard is re-detected from live inputs.
- Taken branch: mem_branch & mem_zero with no mem wait gives pc_src=1, pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1, state RUN. This overrides any load-use stall, because the stalled instruction is squashed.
- Load-use: hazard = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
  - In RUN, a hazard gives pc_write=0, ifid_write=0, idex_flush=1.
  - If LU_BUBBLES>1: state becomes LU_STALL with bub_cnt=1.
  - In LU_STALL: same outputs, bub_cnt increments, and the state returns to RUN when bub_cnt==LU_BUBBLES-1.
  - LU_BUBBLES=1 never enters LU_STALL.
  - Register 0 never causes a hazard.
- stall_cycles increments on every cycle where pc_write=0 and rst_n=1. It saturates at all-ones.
- An asynchronous reset mid-stall or mid-wait returns to RUN immediately. No partial state survives.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, LU_BUBBLES=1 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle defaults; stall_cycles=1.
- Hazard on $0 or unused rt: ex_rd=0, id_rs=0; then ex_rd=7, id_rt=7, id_uses_rt=0 -> no stall in either case.
- Taken branch with simultaneous load-use: mem_branch=1, mem_zero=1, hazard present -> pc_src=1, pc_write=1, all three flushes=1, idex_flush=1, stall_cycles unchanged.
- Mem wait: mem_read=1, mem_ready=0 for 3 cycles, then 1 -> freeze outputs and memwb_bubble=1 for exactly 3 cycles, then normal; stall_cycles=3; mem_err=0.
- Timeout with MEM_TIMEOUT=4: mem_write=1, mem_ready held 0 -> release after 4 frozen cycles, mem_err=1 and stays 1 through later traffic until rst_n=0.
- Reset mid-operation: LU_BUBBLES=3, rst_n pulsed low during the 2nd bubble -> all outputs 0 while low, stall_cycles=0 and state RUN after release, with no residual bubble.
